// File: rtl/ctrl_pkg.sv
// Shared definitions for the pipeline control unit: opcodes, ALU-op codes
// and the per-instruction control bundle carried down the pipeline.
package ctrl_pkg;

   localparam int CTRL_OPCODE_W = 6;
   localparam int CTRL_ALUOP_W  = 2;

   // Primary opcodes understood by the decoder
   localparam logic [CTRL_OPCODE_W-1:0] R_TYPE = 6'b000000;
   localparam logic [CTRL_OPCODE_W-1:0] LW     = 6'b100011;
   localparam logic [CTRL_OPCODE_W-1:0] SW     = 6'b101011;
   localparam logic [CTRL_OPCODE_W-1:0] BEQ    = 6'b000100;
   localparam logic [CTRL_OPCODE_W-1:0] ADDI   = 6'b001000;

   // ALU-op codes handed to the ALU control block
   localparam logic [CTRL_ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
   localparam logic [CTRL_ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
   localparam logic [CTRL_ALUOP_W-1:0] ALUOP_FUNCT = 2'b10;

   // Control bundle for one instruction; each stage register holds one of these
   typedef struct packed {
      logic                    reg_dst;
      logic                    alu_src;
      logic [CTRL_ALUOP_W-1:0] alu_op;
      logic                    branch;
      logic                    mem_read;
      logic                    mem_write;
      logic                    reg_write;
      logic                    mem_to_reg;
      logic                    illegal;
   } ctrl_t;

   // A bubble has every control bit low, including illegal
   localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational ID-stage decoder: opcode + valid -> control bundle.
// Unknown opcodes produce an all-zero bundle with only the illegal bit set.
module ctrl_decode
   import ctrl_pkg::*;
#(
   parameter int OPCODE_W = 6
)(
   input  logic                id_valid,
   input  logic [OPCODE_W-1:0] id_opcode,
   output ctrl_t               ctrl
);

   logic [CTRL_OPCODE_W-1:0] op_norm;

   assign op_norm = CTRL_OPCODE_W'(id_opcode);

   // Table lookup; an empty IF/ID slot decodes to a bubble
   always_comb begin
      ctrl = CTRL_BUBBLE;
      if (id_valid) begin
         case (op_norm)
            R_TYPE: begin
               ctrl.reg_dst   = 1'b1;
               ctrl.alu_op    = ALUOP_FUNCT;
               ctrl.reg_write = 1'b1;
            end
            LW: begin
               ctrl.alu_src    = 1'b1;
               ctrl.alu_op     = ALUOP_ADD;
               ctrl.mem_read   = 1'b1;
               ctrl.reg_write  = 1'b1;
               ctrl.mem_to_reg = 1'b1;
            end
            SW: begin
               ctrl.alu_src   = 1'b1;
               ctrl.alu_op    = ALUOP_ADD;
               ctrl.mem_write = 1'b1;
            end
            BEQ: begin
               ctrl.alu_op = ALUOP_SUB;
               ctrl.branch = 1'b1;
            end
            ADDI: begin
               ctrl.alu_src   = 1'b1;
               ctrl.alu_op    = ALUOP_ADD;
               ctrl.reg_write = 1'b1;
            end
            default: begin
               ctrl.illegal = 1'b1;
            end
         endcase
      end
   end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// 5-stage MIPS pipeline control: decodes in ID, carries the control bundle
// through ID/EX, EX/MEM and MEM/WB, inserts load-use bubbles, squashes
// wrong-path work on a taken branch and counts stall/flush events.
module pipe_ctrl_unit
   import ctrl_pkg::*;
#(
   parameter int OPCODE_W   = 6,
   parameter int REG_ADDR_W = 5,
   parameter int ALUOP_W    = 2,
   parameter int CNT_W      = 16,
   parameter int HAZARD_EN  = 1
)(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  id_valid,
   input  logic [OPCODE_W-1:0]   id_opcode,
   input  logic [REG_ADDR_W-1:0] id_rs,
   input  logic [REG_ADDR_W-1:0] id_rt,
   input  logic [REG_ADDR_W-1:0] ex_rt,
   input  logic                  flush,
   output logic                  pc_write,
   output logic                  ifid_write,
   output logic                  ifid_flush,
   output logic                  ex_reg_dst,
   output logic                  ex_alu_src,
   output logic [ALUOP_W-1:0]    ex_alu_op,
   output logic                  mem_branch,
   output logic                  mem_read,
   output logic                  mem_write,
   output logic                  wb_reg_write,
   output logic                  wb_mem_to_reg,
   output logic                  illegal,
   output logic [CNT_W-1:0]      stall_cnt,
   output logic [CNT_W-1:0]      flush_cnt
);

   ctrl_t dec_ctrl;
   ctrl_t idex_reg, idex_next;
   ctrl_t exmem_reg, exmem_next;
   ctrl_t memwb_reg;

   logic load_use;
   logic stall_take;

   logic [CNT_W-1:0] stall_cnt_reg;
   logic [CNT_W-1:0] flush_cnt_reg;

   ctrl_decode #(
      .OPCODE_W (OPCODE_W)
   ) u_decode (
      .id_valid  (id_valid),
      .id_opcode (id_opcode),
      .ctrl      (dec_ctrl)
   );

   // Load-use detection: the load in EX writes a register the ID instruction reads
   generate
      if (HAZARD_EN != 0) begin : g_hazard
         assign load_use = id_valid & idex_reg.mem_read &
                           ((ex_rt == id_rs) | (ex_rt == id_rt));
      end else begin : g_no_hazard
         logic unused_regs;
         assign unused_regs = ^{id_rs, id_rt, ex_rt};
         assign load_use    = 1'b0;
      end
   endgenerate

   // A taken branch overrides the stall: the stalled instruction is wrong-path anyway
   assign stall_take = load_use & ~flush;

   assign pc_write   = ~stall_take;
   assign ifid_write = ~stall_take;
   assign ifid_flush = flush;

   // Next values for the stage registers that can be forced to a bubble
   always_comb begin
      idex_next  = dec_ctrl;
      exmem_next = idex_reg;
      if (flush || stall_take) begin
         idex_next = CTRL_BUBBLE;
      end
      if (flush) begin
         exmem_next = CTRL_BUBBLE;
      end
   end

   // Stage registers advance every cycle; MEM/WB always takes EX/MEM so the branch retires
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idex_reg  <= CTRL_BUBBLE;
         exmem_reg <= CTRL_BUBBLE;
         memwb_reg <= CTRL_BUBBLE;
      end else begin
         idex_reg  <= idex_next;
         exmem_reg <= exmem_next;
         memwb_reg <= exmem_reg;
      end
   end

   // Saturating count of cycles spent stalled for a load-use hazard
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_reg <= '0;
      end else if (stall_take && (stall_cnt_reg != {CNT_W{1'b1}})) begin
         stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
      end
   end

   // Saturating count of branch-flush cycles
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flush_cnt_reg <= '0;
      end else if (flush && (flush_cnt_reg != {CNT_W{1'b1}})) begin
         flush_cnt_reg <= flush_cnt_reg + CNT_W'(1);
      end
   end

   // Per-stage control taken straight from the stage registers
   assign ex_reg_dst    = idex_reg.reg_dst;
   assign ex_alu_src    = idex_reg.alu_src;
   assign ex_alu_op     = ALUOP_W'(idex_reg.alu_op);
   assign illegal       = idex_reg.illegal;
   assign mem_branch    = exmem_reg.branch;
   assign mem_read      = exmem_reg.mem_read;
   assign mem_write     = exmem_reg.mem_write;
   assign wb_reg_write  = memwb_reg.reg_write;
   assign wb_mem_to_reg = memwb_reg.mem_to_reg;
   assign stall_cnt     = stall_cnt_reg;
   assign flush_cnt     = flush_cnt_reg;

   // Bundle bits that have no consumer once a stage has passed
   logic unused_stage_bits;
   assign unused_stage_bits = ^{exmem_reg.reg_dst, exmem_reg.alu_src, exmem_reg.alu_op,
                                exmem_reg.illegal, memwb_reg.reg_dst, memwb_reg.alu_src,
                                memwb_reg.alu_op, memwb_reg.branch, memwb_reg.mem_read,
                                memwb_reg.mem_write, memwb_reg.illegal};

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Bench for pipe_ctrl_unit: two instances (hazard detection on and off) share
// stimulus and are compared against an instruction-level pipeline model.
module tb_pipe_ctrl_unit;

   localparam int CW   = 4;
   localparam int CMAX = (1 << CW) - 1;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       id_valid = 1'b0;
   logic [5:0] id_opcode = '0;
   logic [4:0] id_rs = '0, id_rt = '0, ex_rt = '0;
   logic       flush = 1'b0;

   // instance 0: hazard detection on
   logic          pc_write0, ifid_write0, ifid_flush0, ex_reg_dst0, ex_alu_src0;
   logic [1:0]    ex_alu_op0;
   logic          mem_branch0, mem_read0, mem_write0, wb_reg_write0, wb_mem_to_reg0, illegal0;
   logic [CW-1:0] stall_cnt0, flush_cnt0;
   // instance 1: hazard detection off
   logic          pc_write1, ifid_write1, ifid_flush1, ex_reg_dst1, ex_alu_src1;
   logic [1:0]    ex_alu_op1;
   logic          mem_branch1, mem_read1, mem_write1, wb_reg_write1, wb_mem_to_reg1, illegal1;
   logic [CW-1:0] stall_cnt1, flush_cnt1;

   always #5 clk = ~clk;

   pipe_ctrl_unit #(.OPCODE_W(6), .REG_ADDR_W(5), .ALUOP_W(2), .CNT_W(CW), .HAZARD_EN(1)) u_dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
      .id_rs(id_rs), .id_rt(id_rt), .ex_rt(ex_rt), .flush(flush),
      .pc_write(pc_write0), .ifid_write(ifid_write0), .ifid_flush(ifid_flush0),
      .ex_reg_dst(ex_reg_dst0), .ex_alu_src(ex_alu_src0), .ex_alu_op(ex_alu_op0),
      .mem_branch(mem_branch0), .mem_read(mem_read0), .mem_write(mem_write0),
      .wb_reg_write(wb_reg_write0), .wb_mem_to_reg(wb_mem_to_reg0), .illegal(illegal0),
      .stall_cnt(stall_cnt0), .flush_cnt(flush_cnt0)
   );

   pipe_ctrl_unit #(.OPCODE_W(6), .REG_ADDR_W(5), .ALUOP_W(2), .CNT_W(CW), .HAZARD_EN(0)) u_noh (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
      .id_rs(id_rs), .id_rt(id_rt), .ex_rt(ex_rt), .flush(flush),
      .pc_write(pc_write1), .ifid_write(ifid_write1), .ifid_flush(ifid_flush1),
      .ex_reg_dst(ex_reg_dst1), .ex_alu_src(ex_alu_src1), .ex_alu_op(ex_alu_op1),
      .mem_branch(mem_branch1), .mem_read(mem_read1), .mem_write(mem_write1),
      .wb_reg_write(wb_reg_write1), .wb_mem_to_reg(wb_mem_to_reg1), .illegal(illegal1),
      .stall_cnt(stall_cnt1), .flush_cnt(flush_cnt1)
   );

   // ---------------- reference model: instructions in flight ----------------
   typedef struct {
      bit         v;
      logic [5:0] op;
   } instr_t;

   instr_t m_ex[2], m_mem[2], m_wb[2];
   int     m_scnt[2], m_fcnt[2];
   int     total = 0;
   int     bad = 0;

   // Control pattern from the opcode table:
   // [9]RegDst [8]ALUSrc [7:6]ALUop [5]Branch [4]MemRead [3]MemWrite [2]RegWrite [1]MemtoReg [0]illegal
   function automatic logic [9:0] ctrl_of(instr_t i);
      if (!i.v) return 10'b0;
      case (i.op)
         6'b000000: return 10'b1_0_10_0_0_0_1_0_0;
         6'b100011: return 10'b0_1_00_0_1_0_1_1_0;
         6'b101011: return 10'b0_1_00_0_0_1_0_0_0;
         6'b000100: return 10'b0_0_01_1_0_0_0_0_0;
         6'b001000: return 10'b0_1_00_0_0_0_1_0_0;
         default:   return 10'b0_0_00_0_0_0_0_0_1;
      endcase
   endfunction

   function automatic bit model_stall(int k);
      if (k != 0) return 1'b0;
      return id_valid && m_ex[k].v && (m_ex[k].op == 6'b100011) &&
             ((ex_rt == id_rs) || (ex_rt == id_rt)) && !flush;
   endfunction

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_ex[k] = '{v: 1'b0, op: 6'b0};
         m_mem[k] = '{v: 1'b0, op: 6'b0};
         m_wb[k] = '{v: 1'b0, op: 6'b0};
         m_scnt[k] = 0;
         m_fcnt[k] = 0;
      end
   endtask

   task automatic check_comb(input string tag);
      bit s0;
      s0 = model_stall(0);
      check_val({tag, ".pc_write"},   pc_write0,   !s0);
      check_val({tag, ".ifid_write"}, ifid_write0, !s0);
      check_val({tag, ".ifid_flush"}, ifid_flush0, flush);
      check_val({tag, ".pc_write_noh"}, {ifid_write1, pc_write1, ifid_flush1}, {1'b1, 1'b1, flush});
   endtask

   task automatic check_regs(input string tag);
      logic [9:0] e, m, w;
      for (int k = 0; k < 2; k++) begin
         e = ctrl_of(m_ex[k]);
         m = ctrl_of(m_mem[k]);
         w = ctrl_of(m_wb[k]);
         if (k == 0) begin
            check_val({tag, ".ex"},  {ex_reg_dst0, ex_alu_src0, ex_alu_op0, illegal0}, {e[9:6], e[0]});
            check_val({tag, ".mem"}, {mem_branch0, mem_read0, mem_write0}, m[5:3]);
            check_val({tag, ".wb"},  {wb_reg_write0, wb_mem_to_reg0}, w[2:1]);
            check_val({tag, ".stall_cnt"}, stall_cnt0, m_scnt[0]);
            check_val({tag, ".flush_cnt"}, flush_cnt0, m_fcnt[0]);
         end else begin
            check_val({tag, ".ex_noh"},  {ex_reg_dst1, ex_alu_src1, ex_alu_op1, illegal1}, {e[9:6], e[0]});
            check_val({tag, ".mem_noh"}, {mem_branch1, mem_read1, mem_write1}, m[5:3]);
            check_val({tag, ".wb_noh"},  {wb_reg_write1, wb_mem_to_reg1}, w[2:1]);
            check_val({tag, ".cnt_noh"}, {stall_cnt1, flush_cnt1}, {CW'(m_scnt[1]), CW'(m_fcnt[1])});
         end
      end
   endtask

   // One clock of stimulus: drive at negedge, check comb, advance model at posedge, check regs
   task automatic step(input string tag, input bit v, input logic [5:0] op,
                       input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] ert, input bit fl);
      bit     st[2];
      instr_t id_i;
      @(negedge clk);
      id_valid = v; id_opcode = op; id_rs = rs; id_rt = rt; ex_rt = ert; flush = fl;
      #1;
      check_comb(tag);
      st[0] = model_stall(0);
      st[1] = model_stall(1);
      id_i = '{v: v, op: op};
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
         if (st[k] && m_scnt[k] < CMAX) m_scnt[k]++;
         if (fl && m_fcnt[k] < CMAX) m_fcnt[k]++;
         m_wb[k]  = m_mem[k];
         m_mem[k] = fl ? '{v: 1'b0, op: 6'b0} : m_ex[k];
         m_ex[k]  = (fl || st[k]) ? '{v: 1'b0, op: 6'b0} : id_i;
      end
      #1;
      check_regs(tag);
      $display("step %s v=%0d op=%b rs=%0d rt=%0d ex_rt=%0d flush=%0d stall_cnt=%0d flush_cnt=%0d",
               tag, v, op, rs, rt, ert, fl, stall_cnt0, flush_cnt0);
   endtask

   localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                          OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_BAD = 6'b111111;

   logic [5:0] op_tab[5];
   logic [4:0] prev_rt;
   logic [5:0] rop;
   logic [4:0] rrs, rrt, rert;

   initial begin
      op_tab[0] = OP_R; op_tab[1] = OP_LW; op_tab[2] = OP_SW; op_tab[3] = OP_BEQ; op_tab[4] = OP_ADDI;
      model_reset();

      // reset state
      repeat (2) @(posedge clk);
      #1;
      check_regs("reset");
      check_comb("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // back-to-back decode of every legal opcode, then drain
      step("lw",   1, OP_LW,   5'd1, 5'd2, 5'd0, 0);
      step("sw",   1, OP_SW,   5'd3, 5'd4, 5'd2, 0);
      step("beq",  1, OP_BEQ,  5'd6, 5'd7, 5'd4, 0);
      step("addi", 1, OP_ADDI, 5'd8, 5'd9, 5'd7, 0);
      step("rtyp", 1, OP_R,    5'd10, 5'd11, 5'd9, 0);
      repeat (3) step("drain", 0, OP_R, 5'd0, 5'd0, 5'd11, 0);

      // load-use: lw rt=5 then add rs=5 -> one stall cycle
      step("lu_lw",  1, OP_LW, 5'd1, 5'd5, 5'd0, 0);
      step("lu_add", 1, OP_R,  5'd5, 5'd6, 5'd5, 0);
      step("lu_add2", 1, OP_R, 5'd5, 5'd6, 5'd5, 0);
      check_val("lu.stall_cnt", stall_cnt0, 1);
      check_val("lu.stall_cnt_noh", stall_cnt1, 0);

      // flush with valid instructions in ID and EX
      step("fl_pre", 1, OP_ADDI, 5'd1, 5'd2, 5'd6, 0);
      step("fl_beq", 1, OP_BEQ,  5'd3, 5'd4, 5'd2, 0);
      step("fl",     1, OP_R,    5'd7, 5'd8, 5'd4, 1);
      step("fl_post", 1, OP_R,   5'd9, 5'd10, 5'd8, 0);

      // load-use and flush together: flush wins
      step("co_lw", 1, OP_LW, 5'd1, 5'd12, 5'd10, 0);
      step("co",    1, OP_R,  5'd12, 5'd3, 5'd12, 1);
      step("co_post", 1, OP_R, 5'd12, 5'd3, 5'd3, 0);

      // illegal opcode shows in EX for one cycle only
      step("ill",      1, OP_BAD, 5'd0, 5'd1, 5'd3, 0);
      step("ill_next", 1, OP_R,   5'd0, 5'd1, 5'd1, 0);
      check_val("ill.gone", illegal0, 0);

      // 20 forced stalls saturate the 4-bit counter
      for (int i = 0; i < 20; i++) begin
         step("sat_lw",  1, OP_LW, 5'd0, 5'd5, 5'd1, 0);
         step("sat_use", 1, OP_R,  5'd5, 5'd1, 5'd5, 0);
         step("sat_go",  1, OP_R,  5'd5, 5'd1, 5'd5, 0);
      end
      check_val("sat.stall_cnt", stall_cnt0, CMAX);

      // asynchronous reset in the middle of a stall
      step("rs_lw", 1, OP_LW, 5'd0, 5'd5, 5'd1, 0);
      @(negedge clk);
      id_valid = 1; id_opcode = OP_R; id_rs = 5'd5; id_rt = 5'd2; ex_rt = 5'd5; flush = 0;
      #1;
      check_val("rs.stalling", pc_write0, 0);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check_regs("rs.async");
      check_val("rs.pc_write", pc_write0, 1);
      @(negedge clk);
      rst_n = 1'b1;

      // randomized traffic
      prev_rt = 5'd0;
      for (int i = 0; i < 400; i++) begin
         rop  = ($urandom_range(0, 9) == 0) ? 6'($urandom) : op_tab[$urandom_range(0, 4)];
         rrs  = 5'($urandom_range(0, 3));
         rrt  = 5'($urandom_range(0, 3));
         rert = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(0, 3)) : prev_rt;
         step("rnd", 1'($urandom_range(0, 7) != 0), rop, rrs, rrt, rert,
              1'($urandom_range(0, 7) == 0));
         prev_rt = rrt;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
